// File: rtl/tiny_riscv_if.sv
// Word-addressed data RAM bus between the tiny_riscv core and its data memory.
// The core drives address/write side (master); the RAM returns read data (slave).
interface tiny_riscv_if;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic        we;
  logic [31:0] rdata;

  modport master (output addr, wdata, we, input rdata);
  modport slave  (input addr, wdata, we, output rdata);
endinterface

// File: rtl/tiny_riscv.sv
// Single-cycle RV32I-subset core: 256-word instruction ROM, 256-word data RAM, 32x32 regfile.
// Both memories start at all zeros; the bench loads them hierarchically.

module tiny_riscv_imem (
  input  logic [7:0]  addr,
  output logic [31:0] instr
);
  logic [31:0] instruction_mem [0:255] = '{default: '0};

  assign instr = instruction_mem[addr];
endmodule

module tiny_riscv_dmem (
  input logic         clk,
  tiny_riscv_if.slave bus
);
  logic [31:0] data_mem [0:255] = '{default: '0};

  // NOTE: the RAM has no reset branch; its contents must survive a core reset,
  // and a reset loop over a memory array would also stop it mapping to block RAM.
  always_ff @(posedge clk) begin
    if (bus.we) data_mem[bus.addr] <= bus.wdata;
  end

  assign bus.rdata = data_mem[bus.addr];
endmodule

module tiny_riscv_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  ra1,
  input  logic [4:0]  ra2,
  output logic [31:0] rd1,
  output logic [31:0] rd2,
  input  logic        we,
  input  logic [4:0]  wa,
  input  logic [31:0] wd
);
  logic [31:0] regs [0:31];

  // NOTE: sequential state uses non-blocking assignments so every register
  // updated on this edge sees the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) regs[i] <= '0;
    end else if (we && wa != 5'd0) begin
      regs[wa] <= wd;
    end
  end

  assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
  assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];
endmodule

module tiny_riscv (
  input logic clk,
  input logic rst
);
  typedef enum logic [6:0] {
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111,
    OP_BRANCH = 7'b1100011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_IMM    = 7'b0010011,
    OP_REG    = 7'b0110011
  } opcode_e;

  logic [31:0] pc, pc_next, pc_plus4, instr;
  opcode_e     opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic        alt;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] rs1_val, rs2_val, alu_b, alu_y, mem_addr, rd_wdata;
  logic        rd_we, mem_we, take_branch;

  tiny_riscv_if dbus ();

  tiny_riscv_imem u_instruction_mem (.addr(pc[9:2]), .instr(instr));
  tiny_riscv_dmem u_data_mem (.clk(clk), .bus(dbus.slave));

  tiny_riscv_regfile u_regs (
    .clk(clk), .rst(rst),
    .ra1(rs1), .ra2(rs2), .rd1(rs1_val), .rd2(rs2_val),
    .we(rd_we), .wa(rd), .wd(rd_wdata)
  );

  assign opcode = opcode_e'(instr[6:0]);
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic sub_sra,
                                      input logic [31:0] a, input logic [31:0] b);
    case (f3)
      3'b000:  return sub_sra ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return sub_sra ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // instr[30] selects SUB/SRA only for register ops and for the immediate right shift.
  assign alt   = instr[30] & ((opcode == OP_REG) | (funct3 == 3'b101));
  assign alu_b = (opcode == OP_REG) ? rs2_val : imm_i;
  assign alu_y = alu(funct3, alt, rs1_val, alu_b);

  always_comb begin
    take_branch = 1'b0;
    case (funct3)
      3'b000:  take_branch = (rs1_val == rs2_val);
      3'b001:  take_branch = (rs1_val != rs2_val);
      3'b100:  take_branch = ($signed(rs1_val) < $signed(rs2_val));
      3'b101:  take_branch = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  take_branch = (rs1_val < rs2_val);
      3'b111:  take_branch = (rs1_val >= rs2_val);
      default: take_branch = 1'b0;
    endcase
  end

  assign mem_addr    = rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i);
  assign dbus.addr   = 8'(mem_addr >> 2);
  assign dbus.wdata  = rs2_val;
  // A store in a cycle cut short by reset must not reach the RAM.
  assign dbus.we     = mem_we & rst;
  assign pc_plus4    = pc + 32'd4;

  // NOTE: every output of this block gets a default first, so no path leaves a
  // signal unassigned and no latch is inferred.
  always_comb begin
    rd_we    = 1'b0;
    rd_wdata = '0;
    mem_we   = 1'b0;
    pc_next  = pc_plus4;
    case (opcode)
      OP_LUI: begin
        rd_we    = 1'b1;
        rd_wdata = imm_u;
      end
      OP_AUIPC: begin
        rd_we    = 1'b1;
        rd_wdata = pc + imm_u;
      end
      OP_JAL: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = pc + imm_j;
      end
      OP_JALR: begin
        rd_we    = 1'b1;
        rd_wdata = pc_plus4;
        pc_next  = (rs1_val + imm_i) & ~32'd1;
      end
      OP_BRANCH: begin
        if (take_branch) pc_next = pc + imm_b;
      end
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          rd_we    = 1'b1;
          rd_wdata = dbus.rdata;
        end
      end
      OP_STORE: begin
        mem_we = (funct3 == 3'b010);
      end
      OP_IMM, OP_REG: begin
        rd_we    = 1'b1;
        rd_wdata = alu_y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pc <= '0;
    else      pc <= {pc_next[31:2], 2'b00};
  end
endmodule

// File: tb/tb_tiny_riscv.sv
// Directed bench for tiny_riscv: loads small hand-assembled programs hierarchically
// and compares registers, data RAM and pc against hand-computed values.
module tb_tiny_riscv;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   wp;

  localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                         OP_JALR = 7'b1100111, OP_LOAD = 7'b0000011,
                         OP_IMM = 7'b0010011;

  tiny_riscv dut (.clk(clk), .rst(rst));

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                        input int rd, input int rs1, input int imm);
    logic [31:0] v = imm;
    return {v[11:0], 5'(rs1), f3, 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                        input int rd, input int rs1, input int rs2);
    return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'b0110011};
  endfunction

  function automatic logic [31:0] enc_s(input logic [2:0] f3, input int rs2,
                                        input int rs1, input int imm);
    logic [31:0] v = imm;
    return {v[11:5], 5'(rs2), 5'(rs1), f3, v[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1,
                                        input int rs2, input int imm);
    logic [31:0] v = imm;
    return {v[12], v[10:5], 5'(rs2), 5'(rs1), f3, v[4:1], v[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm20);
    logic [31:0] v = imm20;
    return {v[19:0], 5'(rd), op};
  endfunction

  function automatic logic [31:0] enc_j(input int rd, input int imm);
    logic [31:0] v = imm;
    return {v[20], v[10:1], v[11], v[19:12], 5'(rd), 7'b1101111};
  endfunction

  function automatic logic [31:0] xreg(input int i);
    return dut.u_regs.regs[i];
  endfunction

  // Enter reset between edges and wipe the instruction ROM.
  task automatic begin_load();
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 256; i++) dut.u_instruction_mem.instruction_mem[i] = 32'h0;
    wp = 0;
  endtask

  task automatic emit(input logic [31:0] w);
    dut.u_instruction_mem.instruction_mem[wp] = w;
    wp++;
  endtask

  task automatic go();
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset held for 20 ns, zero program.
    for (int i = 0; i < 256; i++) dut.u_instruction_mem.instruction_mem[i] = 32'h0;
    repeat (2) @(negedge clk);
    check("reset_pc", dut.pc, 32'h0);
    for (int i = 1; i < 32; i++) check($sformatf("reset_x%0d", i), xreg(i), 32'h0);
    rst = 1'b1;
    run(1);
    check("nop_pc_edge1", dut.pc, 32'h4);
    run(1);
    check("nop_pc_edge2", dut.pc, 32'h8);

    // ALU
    begin_load();
    emit(enc_i(OP_IMM, 3'b000, 1, 0, 5));
    emit(enc_i(OP_IMM, 3'b000, 2, 0, -3));
    emit(enc_r(7'h00, 3'b000, 3, 1, 2));
    emit(enc_r(7'h20, 3'b000, 4, 1, 2));
    emit(enc_r(7'h00, 3'b010, 5, 2, 1));
    emit(enc_r(7'h00, 3'b011, 6, 2, 1));
    emit(enc_i(OP_IMM, 3'b101, 7, 2, 32'h401));
    emit(enc_i(OP_IMM, 3'b100, 8, 2, 32'h0F0));
    emit(enc_i(OP_IMM, 3'b001, 9, 1, 4));
    emit(enc_i(OP_IMM, 3'b101, 10, 2, 28));
    emit(enc_r(7'h00, 3'b110, 11, 8, 9));
    emit(enc_u(OP_AUIPC, 12, 1));
    emit(enc_i(OP_IMM, 3'b011, 13, 1, -1));
    emit(enc_r(7'h20, 3'b101, 14, 2, 1));
    emit(enc_r(7'h00, 3'b101, 15, 2, 1));
    emit(enc_i(OP_IMM, 3'b111, 16, 8, 32'h7FF));
    go();
    run(16);
    check("add", xreg(3), 32'd2);
    check("sub", xreg(4), 32'd8);
    check("slt", xreg(5), 32'd1);
    check("sltu", xreg(6), 32'd0);
    check("srai", xreg(7), 32'hFFFF_FFFE);
    check("xori", xreg(8), 32'hFFFF_FF0D);
    check("slli", xreg(9), 32'h0000_0050);
    check("srli", xreg(10), 32'h0000_000F);
    check("or", xreg(11), 32'hFFFF_FF5D);
    check("auipc", xreg(12), 32'h0000_102C);
    check("sltiu", xreg(13), 32'd1);
    check("sra", xreg(14), 32'hFFFF_FFFF);
    check("srl", xreg(15), 32'h07FF_FFFF);
    check("andi", xreg(16), 32'h0000_070D);
    check("alu_pc", dut.pc, 32'h40);

    // Memory: store/load, ignored low address bits, index wrap
    begin_load();
    emit(enc_i(OP_IMM, 3'b000, 1, 0, 32'h40));
    emit(enc_u(OP_LUI, 2, 32'h12345));
    emit(enc_s(3'b010, 2, 1, 4));
    emit(enc_i(OP_LOAD, 3'b010, 3, 1, 4));
    emit(enc_i(OP_LOAD, 3'b010, 4, 1, 7));
    emit(enc_u(OP_LUI, 5, 1));
    emit(enc_s(3'b010, 1, 5, 8));
    dut.u_data_mem.data_mem[2]  = 32'hFFFF_FFFF;
    dut.u_data_mem.data_mem[17] = 32'h0;
    go();
    run(7);
    check("sw_mem17", dut.u_data_mem.data_mem[17], 32'h1234_5000);
    check("lw_x3", xreg(3), 32'h1234_5000);
    check("lw_lowbits_x4", xreg(4), 32'h1234_5000);
    check("sw_wrap_mem2", dut.u_data_mem.data_mem[2], 32'h0000_0040);

    // Branch/jump, x0 and NOP forms
    begin_load();
    emit(enc_b(3'b000, 0, 0, 8));
    emit(enc_i(OP_IMM, 3'b000, 1, 0, 1));
    emit(enc_j(5, 8));
    emit(enc_i(OP_IMM, 3'b000, 1, 0, 2));
    emit(enc_i(OP_IMM, 3'b000, 6, 0, 32'h21));
    emit(enc_i(OP_JALR, 3'b000, 7, 6, 0));
    emit(enc_i(OP_IMM, 3'b000, 1, 0, 3));
    emit(32'h0);
    emit(enc_i(OP_IMM, 3'b000, 0, 0, 7));
    emit(32'h0000_0000);
    emit(32'h0000_007F);
    emit(enc_i(OP_LOAD, 3'b000, 8, 0, 0));
    emit(enc_s(3'b000, 6, 0, 0));
    emit(32'h0000_0073);
    dut.u_data_mem.data_mem[0] = 32'hA5A5_A5A5;
    go();
    run(2);
    check("jal_pc", dut.pc, 32'h10);
    check("beq_skip_x1", xreg(1), 32'h0);
    check("jal_link_x5", xreg(5), 32'h0C);
    run(2);
    check("jalr_pc", dut.pc, 32'h20);
    check("jalr_link_x7", xreg(7), 32'h18);
    run(1);
    check("x0_write", xreg(0), 32'h0);
    check("x0_pc", dut.pc, 32'h24);
    run(5);
    check("nop_pc", dut.pc, 32'h38);
    check("lb_nop_x8", xreg(8), 32'h0);
    check("sb_nop_mem0", dut.u_data_mem.data_mem[0], 32'hA5A5_A5A5);
    check("nop_x1", xreg(1), 32'h0);
    check("nop_x6", xreg(6), 32'h21);

    // Conditional branch variants
    begin_load();
    emit(enc_i(OP_IMM, 3'b000, 1, 0, -1));
    emit(enc_i(OP_IMM, 3'b000, 2, 0, 1));
    emit(enc_b(3'b100, 1, 2, 8));
    emit(enc_i(OP_IMM, 3'b000, 10, 0, 1));
    emit(enc_b(3'b110, 1, 2, 8));
    emit(enc_i(OP_IMM, 3'b000, 11, 0, 1));
    emit(enc_b(3'b101, 2, 1, 8));
    emit(enc_i(OP_IMM, 3'b000, 12, 0, 1));
    emit(enc_b(3'b111, 2, 1, 8));
    emit(enc_i(OP_IMM, 3'b000, 13, 0, 1));
    emit(enc_b(3'b001, 1, 1, 8));
    emit(enc_i(OP_IMM, 3'b000, 14, 0, 1));
    go();
    run(10);
    check("blt_taken", xreg(10), 32'd0);
    check("bltu_not", xreg(11), 32'd1);
    check("bge_taken", xreg(12), 32'd0);
    check("bgeu_not", xreg(13), 32'd1);
    check("bne_not", xreg(14), 32'd1);
    check("branch_pc", dut.pc, 32'h30);

    // Asynchronous reset mid-program, pending store aborted
    begin_load();
    emit(enc_i(OP_IMM, 3'b000, 1, 0, 32'h40));
    emit(enc_u(OP_LUI, 2, 32'h12345));
    emit(enc_s(3'b010, 2, 1, 4));
    emit(enc_i(OP_LOAD, 3'b010, 3, 1, 4));
    emit(enc_i(OP_IMM, 3'b000, 4, 0, 32'h55));
    emit(enc_i(OP_IMM, 3'b000, 5, 0, 32'h66));
    emit(enc_s(3'b010, 4, 0, 0));
    dut.u_data_mem.data_mem[0]  = 32'hDEAD_BEEF;
    dut.u_data_mem.data_mem[17] = 32'h0;
    go();
    run(6);
    check("pre_reset_pc", dut.pc, 32'h18);
    check("pre_reset_x5", xreg(5), 32'h66);
    rst = 1'b0;
    #1;
    check("async_pc", dut.pc, 32'h0);
    for (int i = 1; i <= 5; i++) check($sformatf("async_x%0d", i), xreg(i), 32'h0);
    check("async_mem17_kept", dut.u_data_mem.data_mem[17], 32'h1234_5000);
    run(1);
    check("aborted_sw_mem0", dut.u_data_mem.data_mem[0], 32'hDEAD_BEEF);
    check("held_pc", dut.pc, 32'h0);
    rst = 1'b1;
    run(1);
    check("restart_pc", dut.pc, 32'h4);
    check("restart_x1", xreg(1), 32'h40);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
